// File: rtl/seg_arb_pkg.sv
// Shared types and constants for the two-master segment display bus arbiter.
package seg_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGnt0 = 2'd1,
        StGnt1 = 2'd2
    } arb_state_e;

    localparam logic [1:0] GrantNone = 2'b00;
    localparam logic [1:0] GrantM0   = 2'b01;
    localparam logic [1:0] GrantM1   = 2'b10;

    // Encoding of the last_served flag
    localparam logic ServedM0 = 1'b0;
    localparam logic ServedM1 = 1'b1;

    localparam int unsigned DefaultTimeout = 16;

endpackage

// File: rtl/seg_arb_timeout.sv
// Grant watchdog: counts granted cycles without s_ack and flags expiry at TIMEOUT-1.
// Instantiated by seg_bus_arbiter only when SEG_ARB_TIMEOUT_EN is defined.
module seg_arb_timeout
    import seg_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic clk,
    input  logic reset_n,
    input  logic active,
    input  logic s_ack,
    output logic expire
);

    localparam logic [7:0] Limit = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;

    // Every grant is preceded by an idle cycle, so clearing while inactive
    // also clears on grant entry.
    always_comb begin
        cnt_d = 8'd0;
        if (active) begin
            cnt_d = s_ack ? cnt_q : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = active && (cnt_q == Limit);

endmodule

// File: rtl/seg_bus_arbiter.sv
// Two-master round-robin arbiter in front of a shared display slave.
// Optional grant timeout enabled by defining SEG_ARB_TIMEOUT_EN.
module seg_bus_arbiter
    import seg_arb_pkg::*;
#(
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          m0_stb,
    input  logic          m0_we,
    input  logic [DW-1:0] m0_dat_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack,
    output logic          m0_err,
    input  logic          m1_stb,
    input  logic          m1_we,
    input  logic [DW-1:0] m1_dat_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack,
    output logic          m1_err,
    output logic          s_stb,
    output logic          s_we,
    output logic [DW-1:0] s_dat_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack,
    output logic [1:0]    grant
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic       expire;

`ifdef SEG_ARB_TIMEOUT_EN
    seg_arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .active  (state_q != StIdle),
        .s_ack   (s_ack),
        .expire  (expire)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^8'(TIMEOUT);
    assign expire         = 1'b0;
`endif

    // s_stb is masked by expire alone (not by s_ack) so a slave whose ack is
    // combinational from s_stb cannot form a loop through this block.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        grant    = GrantNone;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_dat_o  = '0;
        m0_dat_o = '0;
        m1_dat_o = '0;
        m0_ack   = 1'b0;
        m1_ack   = 1'b0;
        m0_err   = 1'b0;
        m1_err   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (m0_stb && m1_stb) begin
                    state_d = (last_q == ServedM1) ? StGnt0 : StGnt1;
                end else if (m0_stb) begin
                    state_d = StGnt0;
                end else if (m1_stb) begin
                    state_d = StGnt1;
                end
            end
            StGnt0: begin
                grant    = GrantM0;
                s_stb    = m0_stb & ~expire;
                s_we     = m0_we;
                s_dat_o  = m0_dat_i;
                m0_dat_o = s_dat_i;
                m0_ack   = s_ack;
                m0_err   = expire & ~s_ack & m0_stb;
                if (s_ack) begin
                    state_d = StIdle;
                    last_d  = ServedM0;
                end else if (!m0_stb) begin
                    state_d = StIdle;
                end else if (expire) begin
                    state_d = StIdle;
                    last_d  = ServedM0;
                end
            end
            StGnt1: begin
                grant    = GrantM1;
                s_stb    = m1_stb & ~expire;
                s_we     = m1_we;
                s_dat_o  = m1_dat_i;
                m1_dat_o = s_dat_i;
                m1_ack   = s_ack;
                m1_err   = expire & ~s_ack & m1_stb;
                if (s_ack) begin
                    state_d = StIdle;
                    last_d  = ServedM1;
                end else if (!m1_stb) begin
                    state_d = StIdle;
                end else if (expire) begin
                    state_d = StIdle;
                    last_d  = ServedM1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            last_q  <= ServedM1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: doc/seg_bus_arbiter.md
SEG_BUS_ARBITER -- requirements
Module: seg_bus_arbiter

Interface
REQ-001 Parameter DW, default 32, data width of every data port.
REQ-002 Parameter TIMEOUT, default 16, cycles a granted master waits for s_ack before abort (range 2..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 m0_stb / m1_stb  input  1  master request, held until its ack or err.
REQ-006 m0_we / m1_we  input  1  master write enable.
REQ-007 m0_dat_i / m1_dat_i  input  DW  master write data.
REQ-008 m0_dat_o / m1_dat_o  output  DW  read data returned to master.
REQ-009 m0_ack / m1_ack  output  1  transaction complete.
REQ-010 m0_err / m1_err  output  1  transaction aborted by timeout; ports always present.
REQ-011 s_stb, s_we  output  1  strobe and write enable to the shared display slave.
REQ-012 s_dat_o  output  DW  write data to slave; s_dat_i  input  DW  read data from slave.
REQ-013 s_ack  input  1  slave acknowledge; may be combinational from s_stb.
REQ-014 grant  output  2  one-hot current grant (bit0 = m0, bit1 = m1), 2'b00 when idle.

Function
REQ-015 FSM states IDLE, GNT0, GNT1; state register updated on clk.
REQ-016 IDLE: single requester -> its GNT state next cycle; both requesting -> master not equal to last_served; none -> stay.
REQ-017 Grant latency is exactly one cycle: request sampled in IDLE at cycle N, s_stb asserted at N+1.
REQ-018 In GNTx: s_stb = mx_stb, s_we = mx_we, s_dat_o = mx_dat_i, mx_dat_o = s_dat_i, mx_ack = s_ack; all combinational.
REQ-019 Non-granted master: ack = 0, err = 0, dat_o = 0; its request is ignored until IDLE.
REQ-020 s_stb = 0, s_we = 0, s_dat_o = 0 in IDLE.
REQ-021 GNTx with s_ack = 1 -> IDLE next cycle, last_served <= x.
REQ-022 GNTx with mx_stb dropped before ack (abandon) -> IDLE next cycle, last_served unchanged.
REQ-023 No back-to-back grants: at least one IDLE cycle between transactions.
REQ-024 Opposite master requesting during a grant waits; it wins the next arbitration because of REQ-016.

Reset
REQ-025 reset_n low: state = IDLE, last_served = m1 (so m0 wins first tie), timeout counter = 0, grant = 0, all ack/err/s_stb = 0, immediately and independent of clk.
REQ-026 Reset asserted mid-transaction drops s_stb asynchronously; no ack or err issued for that transaction.

Configuration
REQ-027 Macro SEG_ARB_TIMEOUT_EN defined: 8-bit counter clears on GNT entry, increments each GNTx cycle without s_ack; at count = TIMEOUT-1 without s_ack, mx_err pulses one cycle, s_stb forced 0 that cycle, FSM -> IDLE, last_served <= x.
REQ-028 s_ack in the same cycle the counter reaches TIMEOUT-1 takes priority: ack, no err.
REQ-029 Macro undefined: no counter logic; m0_err = m1_err = 0 constantly; grant held until ack or abandon.

Structure
REQ-030 Package seg_arb_pkg holds state encoding constants (IDLE, GNT0, GNT1), grant one-hot constants and the default TIMEOUT.
REQ-031 Optional sub-module seg_arb_timeout (counter plus expire flag), instantiated only under SEG_ARB_TIMEOUT_EN.

Verification
REQ-032 m0 write DAT 0x00001234, slave ack = stb -> s_stb one cycle after request, s_dat_o = 0x1234, m0_ack one cycle, FSM back to IDLE.
REQ-033 m0 and m1 request in the same cycle after reset -> m0 served first, m1 served after one IDLE cycle; repeat -> m0 then m1 (round-robin alternation).
REQ-034 m1 read, slave drives s_dat_i = 0x000000C0 -> m1_dat_o = 0xC0 with m1_ack; m0_dat_o = 0 throughout.
REQ-035 With SEG_ARB_TIMEOUT_EN and TIMEOUT = 4, slave holds s_ack = 0 -> m0_err pulses on the 4th granted cycle, grant = 0 next cycle, m0_ack never asserted.
REQ-036 reset_n pulled low while grant = 2'b10 -> grant, s_stb and m1_ack = 0 without waiting for clk; after release, m0 wins the first tie.
